// File: rtl/axis_bit_corr_cfg.sv
// axis_bit_corr_cfg: per-channel +/-1 sequence correlator with coefficients
// that can be loaded at run time. Every accepted input beat updates each
// channel's sample history. The block then emits one output beat per
// correlator k, with tdest = k and tlast on the final correlator.
//
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   s_axis_tvalid/tready/tdata        NUM_PARALLEL signed samples per beat
//   cfg_valid/ready, cfg_sel/data     coefficient write (bit=1 -> +1, 0 -> -1)
//   m_axis_tvalid/tready/tdata        NUM_PARALLEL results per beat
//   m_axis_tdest, m_axis_tlast        correlator index, last-correlator flag
module axis_bit_corr_cfg #(
  parameter int unsigned NUM_PARALLEL = 4,
  parameter int unsigned WAVE_WIDTH   = 6,
  parameter int unsigned ADDER_WIDTH  = 8,
  parameter int unsigned NUM_CORRS    = 2,
  parameter int unsigned CORR_LENGTH  = 4,
  parameter logic [NUM_CORRS*CORR_LENGTH-1:0] CORR_INIT = '0,
  parameter bit          SATURATE     = 1'b1,
  localparam int unsigned CW = (NUM_CORRS > 1) ? $clog2(NUM_CORRS) : 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                s_axis_tvalid,
  output logic                                s_axis_tready,
  input  logic [WAVE_WIDTH*NUM_PARALLEL-1:0]  s_axis_tdata,
  input  logic                                cfg_valid,
  output logic                                cfg_ready,
  input  logic [CW-1:0]                       cfg_sel,
  input  logic [CORR_LENGTH-1:0]              cfg_data,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic [ADDER_WIDTH*NUM_PARALLEL-1:0] m_axis_tdata,
  output logic [CW-1:0]                       m_axis_tdest,
  output logic                                m_axis_tlast
);

  localparam int unsigned ACC_WIDTH = WAVE_WIDTH + $clog2(CORR_LENGTH) + 1;
  localparam int unsigned EXT_W     = (ACC_WIDTH > ADDER_WIDTH) ? ACC_WIDTH : ADDER_WIDTH;
  localparam logic [CW-1:0] K_LAST  = CW'(NUM_CORRS - 1);
  // Clamp limits held in the wider of the two widths; ~max is min there.
  localparam logic signed [EXT_W-1:0] SAT_HI =
    EXT_W'((64'd1 << (ADDER_WIDTH - 1)) - 64'd1);
  localparam logic signed [EXT_W-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                         state_q, state_d;
  logic [CW-1:0]                  k_q, k_d;
  logic                           load_c;
  logic                           slot_free_c;
  logic                           s_accept_c;
  logic                           cfg_accept_c;
  logic signed [WAVE_WIDTH-1:0]   hist_q [NUM_PARALLEL][CORR_LENGTH];
  logic [CORR_LENGTH-1:0]         coef_q [NUM_CORRS];
  logic [CORR_LENGTH-1:0]         coef_sel_c;
  logic signed [ACC_WIDTH-1:0]    acc_c  [NUM_PARALLEL];
  logic [ADDER_WIDTH*NUM_PARALLEL-1:0] sum_c;

  // Fit the full-precision sum into the output width (clamp or wrap).
  function automatic logic [ADDER_WIDTH-1:0] fit_out(input logic signed [ACC_WIDTH-1:0] a);
    logic signed [EXT_W-1:0] v;
    v = EXT_W'(a);
    if (SATURATE) begin
      if (v > SAT_HI)      v = SAT_HI;
      else if (v < SAT_LO) v = SAT_LO;
    end
    return ADDER_WIDTH'(v);
  endfunction

  // Both input ports are open only in IDLE and never while reset is asserted.
  assign s_axis_tready = rst_n & (state_q == IDLE);
  assign cfg_ready     = rst_n & (state_q == IDLE);
  assign s_accept_c    = s_axis_tvalid & s_axis_tready;
  assign cfg_accept_c  = cfg_valid & cfg_ready;
  assign slot_free_c   = ~m_axis_tvalid | m_axis_tready;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Next state: walk k across the correlators whenever the output slot frees up.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    load_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s_accept_c) begin
          state_d = RUN;
          k_d     = '0;
        end
      end
      RUN: begin
        if (slot_free_c) begin
          load_c = 1'b1;
          if (k_q == K_LAST) begin
            state_d = IDLE;
            k_d     = '0;
          end else begin
            k_d = k_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        k_d     = '0;
      end
    endcase
  end

  // Sample histories and coefficient table.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PARALLEL; p++)
        for (int i = 0; i < CORR_LENGTH; i++)
          hist_q[p][i] <= '0;
      for (int k = 0; k < NUM_CORRS; k++)
        coef_q[k] <= CORR_INIT[k*CORR_LENGTH +: CORR_LENGTH];
    end else begin
      if (s_accept_c) begin
        for (int p = 0; p < NUM_PARALLEL; p++) begin
          hist_q[p][0] <= s_axis_tdata[p*WAVE_WIDTH +: WAVE_WIDTH];
          for (int i = 1; i < CORR_LENGTH; i++)
            hist_q[p][i] <= hist_q[p][i-1];
        end
      end
      // Out-of-range selectors are accepted but write nothing.
      if (cfg_accept_c && (32'(cfg_sel) < NUM_CORRS))
        coef_q[cfg_sel] <= cfg_data;
    end
  end

  // Correlation sum for the current k; samples are widened before negation.
  always_comb begin
    coef_sel_c = coef_q[k_q];
    sum_c      = '0;
    for (int p = 0; p < NUM_PARALLEL; p++) begin
      acc_c[p] = '0;
      for (int i = 0; i < CORR_LENGTH; i++) begin
        if (coef_sel_c[i]) acc_c[p] = acc_c[p] + ACC_WIDTH'(hist_q[p][i]);
        else               acc_c[p] = acc_c[p] - ACC_WIDTH'(hist_q[p][i]);
      end
      sum_c[p*ADDER_WIDTH +: ADDER_WIDTH] = fit_out(acc_c[p]);
    end
  end

  // Output register; holds its contents while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tdest  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (load_c) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= sum_c;
      m_axis_tdest  <= k_q;
      m_axis_tlast  <= (k_q == K_LAST);
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: doc/axis_bit_corr_cfg.md
# axis_bit_corr_cfg

Runtime-configurable successor to the fixed-coefficient bit correlator. It accepts AXI-stream beats of NUM_PARALLEL independent sample channels and correlates each channel against NUM_CORRS ±1 sequences. The sequences are loaded at run time through a config port. For each input beat it emits one output beat per correlator, tagged by tdest and tlast. It sits between the ADC unpack stage and peak detection in the xcorr path.

## Interface
- NUM_PARALLEL, 4: sample channels per beat; any value ≥1.
- WAVE_WIDTH, 6: signed sample width.
- ADDER_WIDTH, 8: signed output width per channel.
- NUM_CORRS, 2: number of correlators; any value ≥1.
- CORR_LENGTH, 4: taps per correlator.
- CORR_INIT, all-zero: NUM_CORRS*CORR_LENGTH reset coefficients; correlator k occupies bits [k*CORR_LENGTH +: CORR_LENGTH].
- SATURATE, 1: 1 = clamp output to ADDER_WIDTH; 0 = two's-complement wrap.
- Derived: CW = max(1, clog2(NUM_CORRS)); ACC_WIDTH = WAVE_WIDTH + clog2(CORR_LENGTH) + 1.
- clk  in  1  sole clock.
- rst_n  in  1  reset; synchronous, active-low.
- s_axis_tvalid / s_axis_tready  in/out  1  sample handshake.
- s_axis_tdata  in  WAVE_WIDTH*NUM_PARALLEL  channel p at [p*WAVE_WIDTH +: WAVE_WIDTH].
- cfg_valid / cfg_ready  in/out  1  coefficient write handshake.
- cfg_sel  in  CW  correlator index to write; values ≥ NUM_CORRS are accepted and ignored.
- cfg_data  in  CORR_LENGTH  coefficient bits; bit i = 1 means +1, 0 means −1.
- m_axis_tvalid / m_axis_tready  out/in  1  result handshake.
- m_axis_tdata  out  ADDER_WIDTH*NUM_PARALLEL  channel p at [p*ADDER_WIDTH +: ADDER_WIDTH].
- m_axis_tdest  out  CW  correlator index k.
- m_axis_tlast  out  1  high on the beat with k = NUM_CORRS−1.

## Operation
- Each channel has a history of CORR_LENGTH samples, h_p[0] newest. Every accepted s_axis beat shifts each history by one and inserts the new sample at h_p[0].
- Result: y_{k,p} = Σ_i c_k[i]·h_p[i], where c_k[i] = +1 if coefficient bit i is 1, else −1.
- Samples are sign-extended to ACC_WIDTH before negation, so −2^(WAVE_WIDTH−1) negates exactly. The sum is computed in ACC_WIDTH, then clamped or wrapped to ADDER_WIDTH according to SATURATE.
- FSM states:
  - IDLE: s_axis_tready = 1 and cfg_ready = 1. An s_axis accept moves to RUN with k = 0.
  - RUN: s_axis_tready = 0 and cfg_ready = 0. Each cycle where the output slot is free (~m_axis_tvalid | m_axis_tready), beat k is loaded into the output register and k increments. Loading beat NUM_CORRS−1 returns the FSM to IDLE.
- A cfg write accepted in the same cycle as an s_axis accept applies to that sample's outputs.
- Writes to the same correlator overwrite in order.
- Output register holds tdata, tdest and tlast stable while tvalid=1 and tready=0.
- rst_n = 0 at any time, including mid-RUN:
  - FSM goes to IDLE and k = 0; remaining beats are dropped.
  - Histories are cleared to 0 and coefficients reload CORR_INIT.
  - m_axis_tvalid = 0, tdata = 0, tdest = 0, tlast = 0.
  - s_axis_tready = 0 and cfg_ready = 0 while rst_n is low.

## Timing
- Accept at cycle T. First beat (k = 0) has m_axis_tvalid high in cycle T+2.
- With tready held high, beat k is presented in cycle T+2+k.
- IDLE is re-entered in cycle T+NUM_CORRS+1, so steady-state throughput is one input beat per NUM_CORRS+1 cycles.
- Backpressure stalls RUN without loss. Each stalled cycle delays all later beats and the return to IDLE by one cycle.
- The sum is combinational from history and coefficient registers into the output register, giving one register stage of arithmetic.
- No combinational path from m_axis_tready to s_axis_tready or cfg_ready.

## Test plan
Defaults for all scenarios: NUM_PARALLEL=2, WAVE_WIDTH=6, ADDER_WIDTH=8, NUM_CORRS=2, CORR_LENGTH=4.
- Impulse: cfg k0 = 4'b1111, k1 = 4'b0101. Feed ch0 samples 1,0,0,0 with ch1 = 0 and tready=1 → k0 ch0 = 1,1,1,1; k1 ch0 = 1,−1,1,−1; all ch1 = 0. tdest alternates 0,1 and tlast is set on every k=1 beat.
- Saturation: coef k0 = 4'b0000, ch1 = −32 for 4 beats → 4th k0 ch1 output = 127 with SATURATE=1, −128 with SATURATE=0.
- Backpressure: tready low for 5 cycles from the first tvalid → tdata and tdest are held, s_axis_tready stays 0, and all 2 beats are delivered in order afterwards.
- Config race: cfg k0 = 4'b0000 in the same cycle as accepting ch0 = 3 → k0 ch0 = −3. cfg_ready = 0 during RUN.
- Reset mid-RUN: drop rst_n one cycle after the first beat → all outputs are 0 the next cycle and k1 is never emitted. Next impulse matches scenario 1 using CORR_INIT coefficients.
- Throughput: continuous s_axis_tvalid with tready=1 → accepts every 3 cycles and first-beat latency is 2 cycles.
